pcpu_core: RTL and testbench

Parametrised successor to the team's 8-bit single-cycle CPU.

- **What it adds:** configurable datapath width and register count, a data-memory port with a busy-wait handshake, an instruction-fetch stall input, a `bne` branch and optional shift instructions.
- **Where it sits:** between the instruction cache (`PC`/`INSTRUCTION`) and the data cache (`READ`/`WRITE`/`ADDRESS`).
- **Execution model:** non-memory instructions retire in one cycle; loads and stores stall the core through a two-state FSM.

---
 rtl/pcpu_pkg.sv | 36 +++
 rtl/pcpu_regfile.sv | 34 +++
 rtl/pcpu_core.sv | 171 +++++++++++++++++
 tb/tb_pcpu_core.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// Shared definitions for pcpu_core: opcodes, ALU operations, FSM states and
// instruction field positions.
package pcpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_BNE   = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;
  localparam logic [7:0] OP_SRA   = 8'd15;

  typedef enum logic [2:0] {
    ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_SHL, ALU_SHR, ALU_SRA
  } alu_op_e;

  typedef enum logic {ST_RUN, ST_MEM} state_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 24;
  localparam int RD_MSB  = 23;
  localparam int RD_LSB  = 16;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 0;

endpackage

// File: rtl/pcpu_regfile.sv
// General register file: two combinational read ports, one write port
// committed at the clock edge, so a same-cycle read sees the old value.
module pcpu_regfile #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(REG_CNT)-1:0] waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(REG_CNT)-1:0] raddr1,
  input  logic [$clog2(REG_CNT)-1:0] raddr2,
  output logic [DATA_W-1:0]          rdata1,
  output logic [DATA_W-1:0]          rdata2
);

  logic [DATA_W-1:0] regs_q [REG_CNT];
  logic [DATA_W-1:0] regs_d [REG_CNT];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/pcpu_core.sv
// Parametrised single-cycle core with a RUN/MEM stall FSM for data accesses.
// Define PCPU_SHIFT_EN to build sll/srl/sra (opcodes 13-15); otherwise they are NOPs.
module pcpu_core
  import pcpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 8,
  parameter int PC_W    = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic [PC_W-1:0]   PC,
  input  logic [31:0]       INSTRUCTION,
  input  logic              IBUSYWAIT,
  output logic              READ,
  output logic              WRITE,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              BUSYWAIT
);

  localparam int IDX_W = $clog2(REG_CNT);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                read_q, read_d, write_q, write_d;
  logic [DATA_W-1:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [IDX_W-1:0]    rd_q, rd_d;

  logic [7:0]          opcode, field_imm;
  logic [IDX_W-1:0]    rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0]   imm_ext, rdata1, rdata2, operand_b, add_b, alu_result;
  alu_op_e             alu_op;
  logic                use_imm, sub_en, reg_we_op, is_jump, is_beq, is_bne;
  logic                is_mem, is_load, mem_imm, zero, branch_taken;
  logic [PC_W-1:0]     pc_plus4, offset_ext, branch_target;
  logic                rf_we;
  logic [IDX_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  assign opcode    = INSTRUCTION[OPC_MSB:OPC_LSB];
  assign field_imm = INSTRUCTION[RS2_MSB:RS2_LSB];
  assign rd_idx    = INSTRUCTION[RD_LSB +: IDX_W];
  assign rs1_idx   = INSTRUCTION[RS1_LSB +: IDX_W];
  assign rs2_idx   = INSTRUCTION[RS2_LSB +: IDX_W];
  assign imm_ext   = DATA_W'(field_imm);

  pcpu_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_regfile (
    .clk(CLK), .rst_n(RESET_N), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr1(rs1_idx), .raddr2(rs2_idx), .rdata1(rdata1), .rdata2(rdata2)
  );

  always_comb begin
    alu_op = ALU_FWD; use_imm = 1'b0; sub_en = 1'b0; reg_we_op = 1'b0;
    is_jump = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
    is_mem = 1'b0; is_load = 1'b0; mem_imm = 1'b0;
    case (opcode)
      OP_LOADI: begin reg_we_op = 1'b1; use_imm = 1'b1; end
      OP_MOV:   reg_we_op = 1'b1;
      OP_ADD:   begin alu_op = ALU_ADD; reg_we_op = 1'b1; end
      OP_SUB:   begin alu_op = ALU_ADD; sub_en = 1'b1; reg_we_op = 1'b1; end
      OP_AND:   begin alu_op = ALU_AND; reg_we_op = 1'b1; end
      OP_OR:    begin alu_op = ALU_OR;  reg_we_op = 1'b1; end
      OP_J:     is_jump = 1'b1;
      OP_BEQ:   begin alu_op = ALU_ADD; sub_en = 1'b1; is_beq = 1'b1; end
      OP_BNE:   begin alu_op = ALU_ADD; sub_en = 1'b1; is_bne = 1'b1; end
      OP_LWD:   begin is_mem = 1'b1; is_load = 1'b1; end
      OP_LWI:   begin is_mem = 1'b1; is_load = 1'b1; mem_imm = 1'b1; end
      OP_SWD:   is_mem = 1'b1;
      OP_SWI:   begin is_mem = 1'b1; mem_imm = 1'b1; end
`ifdef PCPU_SHIFT_EN
      OP_SLL:   begin alu_op = ALU_SHL; reg_we_op = 1'b1; end
      OP_SRL:   begin alu_op = ALU_SHR; reg_we_op = 1'b1; end
      OP_SRA:   begin alu_op = ALU_SRA; reg_we_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Subtraction reuses the adder; branch compare is the zero flag of rs1-rs2.
  assign operand_b = use_imm ? imm_ext : rdata2;
  assign add_b     = sub_en ? (~operand_b + DATA_W'(1)) : operand_b;

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = rdata1 + add_b;
      ALU_AND: alu_result = rdata1 & operand_b;
      ALU_OR:  alu_result = rdata1 | operand_b;
`ifdef PCPU_SHIFT_EN
      ALU_SHL: alu_result = rdata1 << field_imm;
      ALU_SHR: alu_result = rdata1 >> field_imm;
      ALU_SRA: alu_result = $signed(rdata1) >>> field_imm;
`endif
      default: alu_result = operand_b;
    endcase
  end

  assign zero          = (alu_result == '0);
  assign branch_taken  = is_jump | (is_beq & zero) | (is_bne & ~zero);
  assign pc_plus4      = pc_q + PC_W'(4);
  assign offset_ext    = PC_W'($signed(INSTRUCTION[RD_MSB:RD_LSB]));
  assign branch_target = pc_plus4 + (offset_ext << 2);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (!IBUSYWAIT && is_mem) state_d = ST_MEM;
      ST_MEM:  if (!BUSYWAIT) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_d = pc_q; read_d = read_q; write_d = write_q;
    addr_d = addr_q; wdata_d = wdata_q; rd_d = rd_q;
    rf_we = 1'b0; rf_waddr = rd_idx; rf_wdata = alu_result;
    case (state_q)
      ST_RUN: if (!IBUSYWAIT) begin
        if (is_mem) begin
          read_d  = is_load;
          write_d = ~is_load;
          addr_d  = mem_imm ? imm_ext : rdata2;
          if (!is_load) wdata_d = rdata1;
          rd_d    = rd_idx;
        end else begin
          rf_we = reg_we_op;
          pc_d  = branch_taken ? branch_target : pc_plus4;
        end
      end
      ST_MEM: if (!BUSYWAIT) begin
        read_d  = 1'b0;
        write_d = 1'b0;
        pc_d    = pc_plus4;
        if (read_q) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = READDATA;
        end
      end
      default: ;
    endcase
  end

  assign PC        = pc_q;
  assign READ      = read_q;
  assign WRITE     = write_q;
  assign ADDRESS   = addr_q;
  assign WRITEDATA = wdata_q;

endmodule

// File: tb/tb_pcpu_core.sv
// Directed bench for pcpu_core (DATA_W=16): vector table of instructions with
// expected PC and memory-port values, plus reset-in-MEM and shift sequences.
module tb_pcpu_core;

  localparam int DW = 16;
  localparam int RC = 8;
  localparam int PW = 32;

  localparam logic [7:0] LOADI = 8'd0, MOV = 8'd1, ADD = 8'd2, SUB = 8'd3;
  localparam logic [7:0] AND_ = 8'd4, OR_ = 8'd5, J = 8'd6, BEQ = 8'd7;
  localparam logic [7:0] LWD = 8'd8, LWI = 8'd9, SWD = 8'd10, SWI = 8'd11;
  localparam logic [7:0] BNE = 8'd12, SLL = 8'd13, SRL = 8'd14, SRA = 8'd15;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic [PW-1:0] PC;
  logic [31:0]   INSTRUCTION = '0;
  logic          IBUSYWAIT = 1'b0;
  logic          READ, WRITE;
  logic [DW-1:0] ADDRESS, WRITEDATA;
  logic [DW-1:0] READDATA = '0;
  logic          BUSYWAIT = 1'b0;

  pcpu_core #(.DATA_W(DW), .REG_CNT(RC), .PC_W(PW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .IBUSYWAIT(IBUSYWAIT), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0]   instr;
    logic          ib;
    logic          bw;
    logic [DW-1:0] rdat;
    logic [PW-1:0] pc;
    logic          rd;
    logic          wr;
    logic          cm;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic ib, input logic bw,
                              input logic [DW-1:0] rdat, input logic [PW-1:0] pc,
                              input logic rd, input logic wr, input logic cm,
                              input logic [DW-1:0] addr, input logic [DW-1:0] wdat);
    vec_t v;
    v.instr = instr; v.ib = ib; v.bw = bw; v.rdat = rdat; v.pc = pc;
    v.rd = rd; v.wr = wr; v.cm = cm; v.addr = addr; v.wdat = wdat;
    return v;
  endfunction

  // Simple one-cycle instruction: only PC and idle memory port checked.
  function automatic vec_t op1(input logic [31:0] instr, input logic [PW-1:0] pc);
    return mk(instr, 1'b0, 1'b0, '0, pc, 1'b0, 1'b0, 1'b0, '0, '0);
  endfunction

  // Observe a register through swi rX,0xF0 with no memory wait.
  task automatic push_store(input logic [7:0] r, input logic [DW-1:0] val, input logic [PW-1:0] pc);
    vecs.push_back(mk(ins(SWI, 8'd0, r, 8'hF0), 1'b0, 1'b0, '0, pc, 1'b0, 1'b1, 1'b1, 16'h00F0, val));
    vecs.push_back(mk(ins(SWI, 8'd0, r, 8'hF0), 1'b0, 1'b0, '0, pc + 4, 1'b0, 1'b0, 1'b1, 16'h00F0, val));
  endtask

  task automatic exec(input vec_t v, input string tag);
    INSTRUCTION = v.instr;
    IBUSYWAIT   = v.ib;
    BUSYWAIT    = v.bw;
    READDATA    = v.rdat;
    @(posedge CLK);
    #1;
    chk({tag, "_pc"}, PC, v.pc);
    chk({tag, "_read"}, {31'd0, READ}, {31'd0, v.rd});
    chk({tag, "_write"}, {31'd0, WRITE}, {31'd0, v.wr});
    if (v.cm) begin
      chk({tag, "_addr"}, {16'd0, ADDRESS}, {16'd0, v.addr});
      chk({tag, "_wdata"}, {16'd0, WRITEDATA}, {16'd0, v.wdat});
    end
  endtask

  initial begin
    // Program: arithmetic, branches, fetch stall, stores/loads with waits.
    vecs.push_back(op1(ins(LOADI, 8'd1, 8'd0, 8'd5), 4));
    vecs.push_back(op1(ins(LOADI, 8'd2, 8'd0, 8'd3), 8));
    vecs.push_back(op1(ins(SUB, 8'd3, 8'd1, 8'd2), 12));
    push_store(8'd3, 16'h0002, 12);
    vecs.push_back(op1(ins(LOADI, 8'd4, 8'd0, 8'd5), 20));
    vecs.push_back(op1(ins(BEQ, 8'hFE, 8'd1, 8'd4), 16));
    vecs.push_back(op1(ins(BNE, 8'hFE, 8'd1, 8'd4), 20));
    vecs.push_back(op1(ins(BNE, 8'd3, 8'd1, 8'd2), 36));
    vecs.push_back(op1(ins(BEQ, 8'd1, 8'd1, 8'd2), 40));
    vecs.push_back(op1(ins(J, 8'd2, 8'd0, 8'd0), 52));
    vecs.push_back(mk(ins(ADD, 8'd5, 8'd1, 8'd2), 1'b1, 1'b0, '0, 52, 1'b0, 1'b0, 1'b0, '0, '0));
    vecs.push_back(mk(ins(ADD, 8'd5, 8'd1, 8'd2), 1'b1, 1'b0, '0, 52, 1'b0, 1'b0, 1'b0, '0, '0));
    vecs.push_back(op1(ins(ADD, 8'd5, 8'd1, 8'd2), 56));
    vecs.push_back(mk(ins(SWD, 8'd0, 8'd5, 8'd3), 1'b0, 1'b0, '0, 56, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h0008));
    vecs.push_back(mk(ins(SWD, 8'd0, 8'd5, 8'd3), 1'b0, 1'b1, '0, 56, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h0008));
    vecs.push_back(mk(ins(SWD, 8'd0, 8'd5, 8'd3), 1'b0, 1'b0, '0, 60, 1'b0, 1'b0, 1'b1, 16'h0002, 16'h0008));
    vecs.push_back(mk(ins(SWI, 8'd0, 8'd1, 8'h10), 1'b0, 1'b0, '0, 60, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(mk(ins(SWI, 8'd0, 8'd1, 8'h10), 1'b0, 1'b1, '0, 60, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(mk(ins(SWI, 8'd0, 8'd1, 8'h10), 1'b1, 1'b1, '0, 60, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(mk(ins(SWI, 8'd0, 8'd1, 8'h10), 1'b0, 1'b1, '0, 60, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(mk(ins(SWI, 8'd0, 8'd1, 8'h10), 1'b1, 1'b0, '0, 64, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(mk(ins(LWI, 8'd6, 8'd0, 8'h10), 1'b0, 1'b1, '0, 64, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(mk(ins(LWI, 8'd6, 8'd0, 8'h10), 1'b0, 1'b0, 16'h005A, 68, 1'b0, 1'b0, 1'b1, 16'h0010, 16'h0005));
    vecs.push_back(op1(ins(8'hFF, 8'd5, 8'd1, 8'd2), 72));
    vecs.push_back(mk(ins(LWD, 8'd7, 8'd0, 8'd5), 1'b0, 1'b0, '0, 72, 1'b1, 1'b0, 1'b1, 16'h0008, 16'h0005));
    vecs.push_back(mk(ins(LWD, 8'd7, 8'd0, 8'd5), 1'b0, 1'b1, 16'h1234, 72, 1'b1, 1'b0, 1'b1, 16'h0008, 16'h0005));
    vecs.push_back(mk(ins(LWD, 8'd7, 8'd0, 8'd5), 1'b0, 1'b0, 16'hBEEF, 76, 1'b0, 1'b0, 1'b1, 16'h0008, 16'h0005));
    vecs.push_back(op1(ins(MOV, 8'd1, 8'd0, 8'd6), 80));
    vecs.push_back(op1(ins(AND_, 8'd2, 8'd7, 8'd6), 84));
    vecs.push_back(op1(ins(OR_, 8'd3, 8'd7, 8'd6), 88));
    vecs.push_back(op1(ins(SUB, 8'd4, 8'd6, 8'd7), 92));
    push_store(8'd1, 16'h005A, 92);
    push_store(8'd2, 16'h004A, 96);
    push_store(8'd3, 16'hBEFF, 100);
    push_store(8'd4, 16'h416B, 104);
    push_store(8'd7, 16'hBEEF, 108);
    push_store(8'd5, 16'h0008, 112);
    vecs.push_back(op1(ins(LOADI, 8'd0, 8'd0, 8'h77), 120));
    push_store(8'd0, 16'h0077, 120);
    vecs.push_back(op1(ins(LOADI, 8'd1, 8'd0, 8'hFF), 128));
    push_store(8'd1, 16'h00FF, 128);

    // Asynchronous reset values, visible before any clock edge.
    #3 RESET_N = 1'b0;
    #1;
    chk("rst_pc", PC, 32'd0);
    chk("rst_read", {31'd0, READ}, 32'd0);
    chk("rst_write", {31'd0, WRITE}, 32'd0);
    chk("rst_addr", {16'd0, ADDRESS}, 32'd0);
    chk("rst_wdata", {16'd0, WRITEDATA}, 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) exec(vecs[i], $sformatf("v%0d", i));

    // Reset while a load is waiting in MEM: access abandoned, restart at 0.
    exec(mk(ins(LWI, 8'd1, 8'd0, 8'h33), 1'b0, 1'b1, '0, 132, 1'b1, 1'b0, 1'b1, 16'h0033, 16'h00FF), "mrst_a");
    exec(mk(ins(LWI, 8'd1, 8'd0, 8'h33), 1'b0, 1'b1, 16'h00AA, 132, 1'b1, 1'b0, 1'b1, 16'h0033, 16'h00FF), "mrst_b");
    #2 RESET_N = 1'b0;
    #1;
    chk("mrst_read", {31'd0, READ}, 32'd0);
    chk("mrst_pc", PC, 32'd0);
    chk("mrst_addr", {16'd0, ADDRESS}, 32'd0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    exec(mk(ins(SWI, 8'd0, 8'd1, 8'hF0), 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 1'b1, 16'h00F0, 16'h0000), "mrst_c");
    exec(mk(ins(SWI, 8'd0, 8'd1, 8'hF0), 1'b0, 1'b0, '0, 4, 1'b0, 1'b0, 1'b1, 16'h00F0, 16'h0000), "mrst_d");
    exec(op1(ins(LOADI, 8'd2, 8'd0, 8'd9), 8), "mrst_e");
    exec(mk(ins(SWI, 8'd0, 8'd2, 8'hF0), 1'b0, 1'b0, '0, 8, 1'b0, 1'b1, 1'b1, 16'h00F0, 16'h0009), "mrst_f");
    exec(mk(ins(SWI, 8'd0, 8'd2, 8'hF0), 1'b0, 1'b0, '0, 12, 1'b0, 1'b0, 1'b1, 16'h00F0, 16'h0009), "mrst_g");

`ifdef PCPU_SHIFT_EN
    vecs.delete();
    vecs.push_back(op1(ins(LOADI, 8'd1, 8'd0, 8'h80), 16));
    vecs.push_back(op1(ins(SLL, 8'd1, 8'd1, 8'd8), 20));
    vecs.push_back(op1(ins(SRA, 8'd2, 8'd1, 8'd4), 24));
    vecs.push_back(op1(ins(SRA, 8'd3, 8'd1, 8'd20), 28));
    vecs.push_back(op1(ins(SRL, 8'd4, 8'd1, 8'd4), 32));
    vecs.push_back(op1(ins(SLL, 8'd5, 8'd1, 8'd16), 36));
    vecs.push_back(op1(ins(SRL, 8'd6, 8'd1, 8'd15), 40));
    push_store(8'd2, 16'hF800, 40);
    push_store(8'd3, 16'hFFFF, 44);
    push_store(8'd4, 16'h0800, 48);
    push_store(8'd5, 16'h0000, 52);
    push_store(8'd6, 16'h0001, 56);
    push_store(8'd1, 16'h8000, 60);
    for (int i = 0; i < vecs.size(); i++) exec(vecs[i], $sformatf("sh%0d", i));
`else
    exec(op1(ins(LOADI, 8'd1, 8'd0, 8'h80), 16), "nosh_a");
    exec(op1(ins(SLL, 8'd1, 8'd1, 8'd1), 20), "nosh_b");
    exec(op1(ins(SRA, 8'd1, 8'd1, 8'd1), 24), "nosh_c");
    exec(mk(ins(SWI, 8'd0, 8'd1, 8'hF0), 1'b0, 1'b0, '0, 24, 1'b0, 1'b1, 1'b1, 16'h00F0, 16'h0080), "nosh_d");
    exec(mk(ins(SWI, 8'd0, 8'd1, 8'hF0), 1'b0, 1'b0, '0, 28, 1'b0, 1'b0, 1'b1, 16'h00F0, 16'h0080), "nosh_e");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
